// File: rtl/ds_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ds_result_buffer_if
// Description : Producer/consumer bundle for ds_result_buffer. The master side
//               drives load and drain. The slave side is the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ds_result_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic               load;
    logic [WIDTH-1:0]   in_data;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [c_CNT_W-1:0] count;
    logic               full;
    logic               empty;
    logic               ovf;

    modport master (
        output load, in_data, clr, out_ready,
        input  out_valid, out_data, count, full, empty, ovf
    );

    modport slave (
        input  load, in_data, clr, out_ready,
        output out_valid, out_data, count, full, empty, ovf
    );
endinterface
`default_nettype wire

// File: rtl/ds_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ds_result_buffer
// Description : DEPTH-entry FWFT result queue with occupancy and sticky
//               overflow flag. When DS_HOLD_LAST_EN is defined, out_data keeps
//               the last popped value while the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ds_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire                 clk,
    input  wire                 rst_l,
    ds_result_buffer_if.slave   bus
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_ovf;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [WIDTH-1:0]    w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_push  = bus.load && (!w_full || w_pop);
    assign w_drop  = bus.load && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage is deliberately unreset; entries are only read while occupied.
    always_ff @(posedge clk) begin
        if (w_push && !bus.clr) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef DS_HOLD_LAST_EN
    logic [WIDTH-1:0] r_last;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_last <= '0;
        end else if (bus.clr) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    assign bus.out_data = w_empty ? r_last : w_head;
`else
    assign bus.out_data = w_empty ? '0 : w_head;
`endif

    assign bus.out_valid = !w_empty;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
